// File: rtl/fp_add_normalize_if.sv
// fp_add_normalize_if: valid/ready bundle between the adder, the normalizer and its consumer
// in_*  : raw sum beat from the adder (sign, biased exp, MANT_W+1 sum, zero-group count)
// out_* : normalized sign/exp/fraction beat plus guard and ovf/uf/zero flags
// master drives in_* and out_ready; slave (the normalizer) drives in_ready and out_*
interface fp_add_normalize_if #(
   parameter int MANT_W = 24,
   parameter int EXP_W  = 8
);
   logic              in_valid;
   logic              in_ready;
   logic              in_sign;
   logic [EXP_W-1:0]  in_exp;
   logic [MANT_W:0]   in_mant;
   logic [2:0]        in_coarse;
   logic              out_valid;
   logic              out_ready;
   logic              out_sign;
   logic [EXP_W-1:0]  out_exp;
   logic [MANT_W-2:0] out_mant;
   logic              out_guard;
   logic              out_ovf;
   logic              out_uf;
   logic              out_zero;
   modport master (
      output in_valid, in_sign, in_exp, in_mant, in_coarse, out_ready,
      input  in_ready, out_valid, out_sign, out_exp, out_mant, out_guard, out_ovf, out_uf, out_zero
   );
   modport slave (
      input  in_valid, in_sign, in_exp, in_mant, in_coarse, out_ready,
      output in_ready, out_valid, out_sign, out_exp, out_mant, out_guard, out_ovf, out_uf, out_zero
   );
endinterface

// File: rtl/fp_add_normalize.sv
// fp_add_normalize: two-stage post-add normalizer (coarse group shift, then fine shift and exponent checks)
// clk, rst : rising-edge clock, synchronous active-high reset
// bus      : slave side of fp_add_normalize_if (raw sum in, normalized sign/exp/fraction and flags out)
module fp_add_normalize #(
   parameter int MANT_W = 24,
   parameter int EXP_W  = 8,
   parameter int GRP_W  = 4
) (
   input logic clk,
   input logic rst,
   fp_add_normalize_if.slave bus
);
   localparam int XW = EXP_W + 2;
   localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);
   typedef struct packed {
      logic                 v;
      logic                 sign;
      logic signed [XW-1:0] exp;
      logic [MANT_W-1:0]    mant;
      logic                 guard;
      logic                 zero;
   } s1_t;
   typedef struct packed {
      logic              v;
      logic              sign;
      logic [EXP_W-1:0]  exp;
      logic [MANT_W-2:0] mant;
      logic              guard;
      logic              ovf;
      logic              uf;
      logic              zero;
   } s2_t;
   s1_t s1_q, s1_d;
   s2_t s2_q, s2_d;
   logic s1_adv, s2_adv;
   logic signed [XW-1:0] ex, sh, f, ne;
   logic [MANT_W-2:0] nm;
   always_comb begin
      s2_adv = !s2_q.v || bus.out_ready;
      s1_adv = !s1_q.v || s2_adv;
      ex = XW'(bus.in_exp);
      sh = XW'(GRP_W * int'(bus.in_coarse));
      s1_d = s1_q;
      if (s1_adv) begin
         s1_d.v = bus.in_valid;
         s1_d.sign = bus.in_sign;
         s1_d.zero = bus.in_mant == '0;
         s1_d.guard = bus.in_mant[MANT_W] & bus.in_mant[0];
         s1_d.mant = bus.in_mant[MANT_W] ? bus.in_mant[MANT_W:1] : bus.in_mant[MANT_W-1:0] << sh;
         s1_d.exp = bus.in_mant[MANT_W] ? ex + XW'(1) : ex - sh;
      end
      // topmost set bit within the leading group decides the fine shift
      f = XW'(GRP_W - 1);
      for (int i = GRP_W - 1; i >= 0; i--)
         if (s1_q.mant[MANT_W-1-i]) f = XW'(i);
      nm = (MANT_W-1)'(s1_q.mant << f);
      ne = s1_q.exp - f;
      s2_d = s2_q;
      if (s2_adv) begin
         s2_d.v = s1_q.v;
         s2_d.sign = s1_q.sign;
         s2_d.guard = s1_q.guard;
         s2_d.zero = s1_q.zero;
         s2_d.ovf = !s1_q.zero && ne >= EXP_MAX;
         s2_d.uf = !s1_q.zero && ne < EXP_MAX && (ne[XW-1] || ne == '0);
         s2_d.exp = s2_d.ovf ? '1 : (s2_d.uf || s1_q.zero) ? '0 : ne[EXP_W-1:0];
         s2_d.mant = (s2_d.ovf || s2_d.uf || s1_q.zero) ? '0 : nm;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q <= '0;
         s2_q <= '0;
      end else begin
         s1_q <= s1_d;
         s2_q <= s2_d;
      end
   end
   assign bus.in_ready  = s1_adv;
   assign bus.out_valid = s2_q.v;
   assign bus.out_sign  = s2_q.sign;
   assign bus.out_exp   = s2_q.exp;
   assign bus.out_mant  = s2_q.mant;
   assign bus.out_guard = s2_q.guard;
   assign bus.out_ovf   = s2_q.ovf;
   assign bus.out_uf    = s2_q.uf;
   assign bus.out_zero  = s2_q.zero;
endmodule

// File: tb/tb_fp_add_normalize.sv
// tb_fp_add_normalize: directed-vector bench with a value-level normalization model and scoreboard
module tb_fp_add_normalize;
   logic clk = 0;
   logic rst = 1;
   int tests = 0;
   int fails = 0;
   logic rst_prev = 0;
   logic [35:0] q[$];
   logic [35:0] act;
   fp_add_normalize_if bus ();
   fp_add_normalize dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
      tests++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s: got %h expected %h", n, a, e);
      end
   endtask
   // normalize by locating the most significant set bit of the raw sum
   function automatic logic [35:0] model(input logic s, input logic [7:0] e, input logic [24:0] m);
      int p, ex;
      logic [24:0] t;
      logic g;
      if (m == 0) return {s, 8'd0, 23'd0, 1'b0, 3'b001};
      p = 24;
      while (!m[p]) p--;
      ex = int'(e) + p - 23;
      g = (p == 24) ? m[0] : 1'b0;
      t = (p == 24) ? m >> 1 : m << (23 - p);
      if (ex >= 255) return {s, 8'hff, 23'd0, g, 3'b100};
      if (ex <= 0) return {s, 8'd0, 23'd0, g, 3'b010};
      return {s, 8'(ex), t[22:0], g, 3'b000};
   endfunction
   always @(negedge clk) begin
      act = {bus.out_sign, bus.out_exp, bus.out_mant, bus.out_guard, bus.out_ovf, bus.out_uf, bus.out_zero};
      if (rst_prev) chk("reset_state", {26'd0, bus.out_valid, bus.in_ready, act}, {26'd0, 1'b0, 1'b1, 36'd0});
      if (rst) q.delete();
      else begin
         if (bus.out_valid) begin
            if (q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_beat: got %h expected none", act);
            end else begin
               chk("beat", {28'd0, act}, {28'd0, q[0]});
               if (bus.out_ready) void'(q.pop_front());
            end
         end
         if (bus.in_valid && bus.in_ready) q.push_back(model(bus.in_sign, bus.in_exp, bus.in_mant));
      end
      rst_prev = rst;
   end
   task automatic send(input logic s, input logic [7:0] e, input logic [24:0] m, input logic [2:0] c);
      int n = 0;
      bus.in_sign = s;
      bus.in_exp = e;
      bus.in_mant = m;
      bus.in_coarse = c;
      bus.in_valid = 1;
      @(negedge clk);
      while (!bus.in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!bus.in_ready) begin
         tests++;
         fails++;
         $display("FAIL send_timeout: got in_ready 0 expected 1");
      end
      @(posedge clk);
      #1 bus.in_valid = 0;
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end
   initial begin
      int n;
      bus.in_valid = 0;
      bus.in_sign = 0;
      bus.in_exp = 0;
      bus.in_mant = 0;
      bus.in_coarse = 0;
      bus.out_ready = 1;
      chk("pin_plain", {28'd0, model(0, 100, 25'h0800000)}, {28'd0, 1'b0, 8'd100, 23'd0, 1'b0, 3'b000});
      chk("pin_carry", {28'd0, model(0, 100, 25'h1000001)}, {28'd0, 1'b0, 8'd101, 23'd0, 1'b1, 3'b000});
      chk("pin_ovf", {28'd0, model(0, 254, 25'h1000001)}, {28'd0, 1'b0, 8'hff, 23'd0, 1'b1, 3'b100});
      chk("pin_shift", {28'd0, model(0, 100, 25'h0000400)}, {28'd0, 1'b0, 8'd87, 23'd0, 1'b0, 3'b000});
      chk("pin_uf", {28'd0, model(0, 10, 25'h0000400)}, {28'd0, 1'b0, 8'd0, 23'd0, 1'b0, 3'b010});
      chk("pin_zero", {28'd0, model(1, 77, 25'h0)}, {28'd0, 1'b1, 8'd0, 23'd0, 1'b0, 3'b001});
      chk("pin_frac", {28'd0, model(0, 100, 25'h0012345)}, {28'd0, 1'b0, 8'd93, 23'h11A280, 1'b0, 3'b000});
      chk("pin_cfrac", {28'd0, model(1, 50, 25'h1800003)}, {28'd0, 1'b1, 8'd51, 23'h400001, 1'b1, 3'b000});
      repeat (3) @(posedge clk);
      #1 rst = 0;
      send(0, 100, 25'h0800000, 0);
      @(negedge clk) chk("latency_1", {63'd0, bus.out_valid}, 64'd0);
      @(negedge clk) chk("latency_2", {63'd0, bus.out_valid}, 64'd1);
      @(posedge clk);
      #1;
      send(0, 100, 25'h1000001, 0);
      send(0, 254, 25'h1000001, 0);
      send(0, 100, 25'h0000400, 3);
      send(0, 10, 25'h0000400, 3);
      send(1, 0, 25'h0000000, 6);
      send(0, 100, 25'h0012345, 1);
      send(1, 50, 25'h1800003, 0);
      send(0, 100, 25'h0ABCDEF, 0);
      send(0, 30, 25'h0000001, 5);
      send(0, 255, 25'h0800000, 0);
      send(0, 1, 25'h0400000, 0);
      send(1, 1, 25'h0800000, 0);
      send(0, 0, 25'h1000000, 0);
      send(0, 23, 25'h0000001, 5);
      repeat (4) @(posedge clk);
      #1 bus.out_ready = 0;
      send(0, 60, 25'h0F00000, 0);
      send(1, 61, 25'h00F0000, 1);
      bus.in_sign = 0;
      bus.in_exp = 62;
      bus.in_mant = 25'h000F000;
      bus.in_coarse = 2;
      bus.in_valid = 1;
      @(negedge clk) chk("bp_ready_1", {63'd0, bus.in_ready}, 64'd0);
      repeat (3) @(negedge clk);
      chk("bp_ready_2", {63'd0, bus.in_ready}, 64'd0);
      chk("bp_valid", {63'd0, bus.out_valid}, 64'd1);
      @(posedge clk);
      #1 bus.out_ready = 1;
      n = 0;
      @(negedge clk);
      while (!bus.in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("bp_release", {63'd0, bus.in_ready}, 64'd1);
      @(posedge clk);
      #1 bus.in_valid = 0;
      repeat (5) @(posedge clk);
      #1 bus.out_ready = 0;
      send(0, 90, 25'h0800001, 0);
      send(0, 91, 25'h0800002, 0);
      rst = 1;
      @(posedge clk);
      #1 rst = 0;
      @(negedge clk) chk("rst_mid", {63'd0, bus.out_valid}, 64'd0);
      @(posedge clk);
      #1 bus.out_ready = 1;
      repeat (4) @(posedge clk);
      #1;
      send(0, 120, 25'h0030000, 1);
      repeat (5) @(posedge clk);
      chk("drain", 64'(q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
